// File: rtl/bpu_access_ctrl.sv
// bpu_access_ctrl: single-port BHT arbiter between fetch lookups and queued ID resolutions, with clear sweep.
// Defining BPU_CTRL_PERF_EN builds saturating lookup/update/stall counters; otherwise they read 0.
module bpu_access_ctrl #(
    parameter int N            = 32,
    parameter int INDEX_WIDTH  = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_lu_valid,
    input  logic [N-1:0]           i_lu_pc,
    output logic                   o_lu_ready,
    input  logic                   i_rs_valid,
    input  logic [N-1:0]           i_rs_pc,
    input  logic [N-1:0]           i_rs_target,
    input  logic                   i_rs_taken,
    input  logic                   i_rs_hit,
    output logic                   o_rs_ready,
    input  logic                   i_clear,
    output logic [1:0]             o_tbl_cmd,
    output logic [INDEX_WIDTH-1:0] o_tbl_index,
    output logic [N-1:0]           o_tbl_wr_pc,
    output logic [N-1:0]           o_tbl_wr_target,
    output logic [1:0]             o_tbl_wr_ctr,
    output logic                   o_tbl_taken,
    output logic                   o_init_done,
    output logic [31:0]            o_perf_lookups,
    output logic [31:0]            o_perf_updates,
    output logic [31:0]            o_perf_stalls
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [1:0] CMD_NOP = 2'b00, CMD_READ = 2'b01, CMD_WRITE = 2'b10, CMD_TRAIN = 2'b11;

    typedef enum logic [1:0] {INIT, RUN, DRAIN} state_t;

    state_t                 state;
    logic [INDEX_WIDTH-1:0] idx;
    logic [N-1:0]           q_pc     [FIFO_DEPTH];
    logic [N-1:0]           q_target [FIFO_DEPTH];
    logic                   q_taken  [FIFO_DEPTH];
    logic                   q_hit    [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count;
    logic [SW-1:0]          starve_cnt;
    logic                   full, empty, push, pop, grant, forced, head_wr, drain_done;
    logic                   unused_lu_pc;

    assign full       = count == (AW+1)'(FIFO_DEPTH);
    assign empty      = count == '0;
    assign forced     = full || starve_cnt >= SW'(STARVE_LIMIT);
    assign push       = i_rs_valid && !full;
    assign pop        = !empty && ((state == RUN && (forced || !i_lu_valid)) || state == DRAIN);
    assign grant      = state == RUN && i_lu_valid && (empty || !forced);
    assign head_wr    = pop && !q_hit[rd_ptr];
    assign drain_done = count == (AW+1)'(pop) && !push;

    assign o_lu_ready      = grant;
    assign o_rs_ready      = !full;
    assign o_init_done     = state == RUN;
    assign o_tbl_cmd       = state == INIT ? CMD_WRITE : pop ? (q_hit[rd_ptr] ? CMD_TRAIN : CMD_WRITE) :
                             grant ? CMD_READ : CMD_NOP;
    assign o_tbl_index     = state == INIT ? idx : pop ? q_pc[rd_ptr][INDEX_WIDTH-1:0] :
                             grant ? i_lu_pc[INDEX_WIDTH-1:0] : '0;
    assign o_tbl_wr_pc     = head_wr ? q_pc[rd_ptr] : '0;
    assign o_tbl_wr_target = head_wr ? q_target[rd_ptr] : '0;
    assign o_tbl_wr_ctr    = o_tbl_cmd == CMD_WRITE ? 2'b01 : 2'b00;
    assign o_tbl_taken     = pop && q_hit[rd_ptr] && q_taken[rd_ptr];
    assign unused_lu_pc    = ^i_lu_pc[N-1:INDEX_WIDTH];

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]     <= i_rs_pc;
            q_target[wr_ptr] <= i_rs_target;
            q_taken[wr_ptr]  <= i_rs_taken;
            q_hit[wr_ptr]    <= i_rs_hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT;
            idx        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count      <= count + (AW+1)'(push) - (AW+1)'(pop);
            starve_cnt <= (pop || empty) ? '0 :
                          (state == RUN && starve_cnt < SW'(STARVE_LIMIT)) ? starve_cnt + SW'(1) : starve_cnt;
            case (state)
                INIT: begin
                    idx <= i_clear ? '0 : idx + INDEX_WIDTH'(1);
                    if (!i_clear && &idx) state <= RUN;
                end
                RUN: if (i_clear) state <= DRAIN;
                DRAIN: if (drain_done) begin
                    state <= INIT;
                    idx   <= '0;
                end
                default: state <= INIT;
            endcase
        end
    end

`ifdef BPU_CTRL_PERF_EN
    logic [31:0] perf_lu, perf_up, perf_st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lu <= '0;
            perf_up <= '0;
            perf_st <= '0;
        end else begin
            if (grant && !(&perf_lu)) perf_lu <= perf_lu + 32'd1;
            if (pop && !(&perf_up)) perf_up <= perf_up + 32'd1;
            if (i_lu_valid && !grant && !(&perf_st)) perf_st <= perf_st + 32'd1;
        end
    end

    assign o_perf_lookups = perf_lu;
    assign o_perf_updates = perf_up;
    assign o_perf_stalls  = perf_st;
`else
    assign o_perf_lookups = '0;
    assign o_perf_updates = '0;
    assign o_perf_stalls  = '0;
`endif
endmodule

// File: tb/tb_bpu_access_ctrl.sv
// tb_bpu_access_ctrl: randomized bench for bpu_access_ctrl against a queue-based reference model.
module tb_bpu_access_ctrl;
    localparam int N = 32, IW = 8, FD = 4, SL = 3;

    typedef struct {
        logic [N-1:0] pc;
        logic [N-1:0] target;
        logic         taken;
        logic         hit;
    } res_t;

    logic          clk = 1'b0, rst = 1'b1;
    logic          lu_valid = 1'b0, rs_valid = 1'b0, rs_taken = 1'b0, rs_hit = 1'b0, clear = 1'b0;
    logic [N-1:0]  lu_pc = '0, rs_pc = '0, rs_target = '0;
    logic          lu_ready, rs_ready, tbl_taken, init_done;
    logic [1:0]    tbl_cmd, tbl_wr_ctr;
    logic [IW-1:0] tbl_index;
    logic [N-1:0]  tbl_wr_pc, tbl_wr_target;
    logic [31:0]   perf_lookups, perf_updates, perf_stalls;

    always #5 clk = ~clk;

    bpu_access_ctrl dut (
        .clk(clk), .rst(rst),
        .i_lu_valid(lu_valid), .i_lu_pc(lu_pc), .o_lu_ready(lu_ready),
        .i_rs_valid(rs_valid), .i_rs_pc(rs_pc), .i_rs_target(rs_target),
        .i_rs_taken(rs_taken), .i_rs_hit(rs_hit), .o_rs_ready(rs_ready),
        .i_clear(clear),
        .o_tbl_cmd(tbl_cmd), .o_tbl_index(tbl_index), .o_tbl_wr_pc(tbl_wr_pc),
        .o_tbl_wr_target(tbl_wr_target), .o_tbl_wr_ctr(tbl_wr_ctr), .o_tbl_taken(tbl_taken),
        .o_init_done(init_done),
        .o_perf_lookups(perf_lookups), .o_perf_updates(perf_updates), .o_perf_stalls(perf_stalls)
    );

    // model: mode 0 = sweeping, 1 = running, 2 = draining
    res_t        q[$];
    int          mode, sweep, starve;
    int unsigned m_lu, m_up, m_st;
    int          n_cmp = 0, n_bad = 0;

    logic [1:0]    e_cmd, e_ctr;
    logic [IW-1:0] e_idx;
    logic [N-1:0]  e_pc, e_tg;
    logic          e_tk, e_lr, e_pop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset;
        q.delete();
        mode = 0;
        sweep = 0;
        starve = 0;
        m_lu = 0;
        m_up = 0;
        m_st = 0;
    endtask

    task automatic predict;
        res_t h;
        e_cmd = 2'b00; e_ctr = 2'b00; e_idx = '0; e_pc = '0; e_tg = '0;
        e_tk = 1'b0; e_lr = 1'b0; e_pop = 1'b0;
        if (mode == 0) begin
            e_cmd = 2'b10;
            e_idx = sweep[IW-1:0];
            e_ctr = 2'b01;
        end else begin
            if (mode == 2) e_pop = q.size() > 0;
            else if (q.size() > 0 && (q.size() == FD || starve >= SL)) e_pop = 1'b1;
            else if (lu_valid) begin
                e_lr = 1'b1;
                e_cmd = 2'b01;
                e_idx = lu_pc[IW-1:0];
            end else e_pop = q.size() > 0;
            if (e_pop) begin
                h = q[0];
                e_idx = h.pc[IW-1:0];
                if (h.hit) begin
                    e_cmd = 2'b11;
                    e_tk = h.taken;
                end else begin
                    e_cmd = 2'b10;
                    e_pc = h.pc;
                    e_tg = h.target;
                    e_ctr = 2'b01;
                end
            end
        end
    endtask

    task automatic check_outputs;
        chk("cmd", 32'(tbl_cmd), 32'(e_cmd));
        chk("index", 32'(tbl_index), 32'(e_idx));
        chk("wr_pc", tbl_wr_pc, e_pc);
        chk("wr_target", tbl_wr_target, e_tg);
        chk("wr_ctr", 32'(tbl_wr_ctr), 32'(e_ctr));
        chk("taken", 32'(tbl_taken), 32'(e_tk));
        chk("lu_ready", 32'(lu_ready), 32'(e_lr));
        chk("rs_ready", 32'(rs_ready), 32'(q.size() != FD));
        chk("init_done", 32'(init_done), 32'(mode == 1));
`ifdef BPU_CTRL_PERF_EN
        chk("perf_lookups", perf_lookups, m_lu);
        chk("perf_updates", perf_updates, m_up);
        chk("perf_stalls", perf_stalls, m_st);
`else
        chk("perf_lookups", perf_lookups, 32'd0);
        chk("perf_updates", perf_updates, 32'd0);
        chk("perf_stalls", perf_stalls, 32'd0);
`endif
    endtask

    task automatic advance;
        int   sz0;
        res_t r;
        sz0 = q.size();
        r.pc = rs_pc; r.target = rs_target; r.taken = rs_taken; r.hit = rs_hit;
        if (e_lr) m_lu++;
        if (e_pop) m_up++;
        if (lu_valid && !e_lr) m_st++;
        if (e_pop) q.delete(0);
        if (rs_valid && sz0 != FD) q.push_back(r);
        if (e_pop || sz0 == 0) starve = 0;
        else if (mode == 1 && starve < SL) starve++;
        if (mode == 0) begin
            if (clear) sweep = 0;
            else if (sweep == (1 << IW) - 1) mode = 1;
            else sweep++;
        end else if (mode == 1) begin
            if (clear) mode = 2;
        end else if (q.size() == 0) begin
            mode = 0;
            sweep = 0;
        end
    endtask

    task automatic step(input logic lv, input logic [N-1:0] lp, input logic rv, input res_t r, input logic clr);
        lu_valid = lv; lu_pc = lp;
        rs_valid = rv; rs_pc = r.pc; rs_target = r.target; rs_taken = r.taken; rs_hit = r.hit;
        clear = clr;
        predict();
        #3;
        check_outputs();
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic rnd_step(input int lv_pct, input int rs_pct, input int clr_pm);
        res_t r;
        r.pc = $urandom; r.target = $urandom;
        r.taken = 1'($urandom_range(0, 1)); r.hit = 1'($urandom_range(0, 1));
        step(1'($urandom_range(0, 99) < lv_pct), $urandom, 1'($urandom_range(0, 99) < rs_pct), r,
             1'($urandom_range(0, 999) < clr_pm));
    endtask

    task automatic reset_check;
        lu_valid = 1'b0; rs_valid = 1'b0; clear = 1'b0;
        rst = 1'b1;
        #2;
        model_reset();
        predict();
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    res_t r0, r1;

    initial begin
        model_reset();
        r0 = '{pc: '0, target: '0, taken: 1'b0, hit: 1'b0};
        @(posedge clk);
        #1;
        reset_check();
        for (int i = 0; i < 256; i++) step(1'b1, $urandom, 1'b0, r0, 1'b0);
        chk("init_done_after_sweep", 32'(init_done), 32'd1);
        step(1'b1, 32'h1000_0040, 1'b0, r0, 1'b0);
        r1 = '{pc: 32'h0000_0144, target: 32'h0000_2000, taken: 1'b1, hit: 1'b1};
        step(1'b1, $urandom, 1'b1, r1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b0, r0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            r1 = '{pc: $urandom, target: $urandom, taken: 1'b0, hit: 1'b0};
            step(1'b1, $urandom, 1'b1, r1, 1'b0);
        end
        for (int i = 0; i < 20; i++) step(1'b1, $urandom, 1'b0, r0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            r1 = '{pc: $urandom, target: $urandom, taken: 1'b1, hit: 1'b0};
            step(1'b1, $urandom, 1'b1, r1, 1'b0);
        end
        step(1'b1, $urandom, 1'b0, r0, 1'b1);
        for (int i = 0; i < 270; i++) step(1'b1, $urandom, 1'b0, r0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) reset_check();
            rnd_step(i < 400 ? 100 : 70, 40, 6);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bpu_access_ctrl.md
# bpu_access_ctrl

Access controller and scheduler for the single-ported branch history table (BHT) of the branch prediction unit. Each cycle it grants the one table port to either a fetch-side lookup or a queued branch-resolution update from ID, buffers resolutions in a small FIFO, and prevents update starvation. It also sequences a full-table clear sweep after reset and on request, and holds lookups off until the table is valid.

## Interface
- `N`, 32: PC/target width (from parameters.vh).
- `INDEX_WIDTH`, 8: BHT index width; the table has 2^INDEX_WIDTH entries; index = pc[INDEX_WIDTH-1:0].
- `FIFO_DEPTH`, 4: resolution FIFO entries; must be a power of two, ≥2.
- `STARVE_LIMIT`, 3: consecutive cycles a pending update may lose arbitration before it is forced.

Ports:
- `clk`  in  1  clock; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_lu_valid`  in  1  fetch requests a prediction lookup.
- `i_lu_pc`  in  N  lookup PC.
- `o_lu_ready`  out  1  lookup granted this cycle.
- `i_rs_valid`  in  1  ID presents a resolved branch.
- `i_rs_pc`  in  N  resolved branch PC.
- `i_rs_target`  in  N  resolved target PC.
- `i_rs_taken`  in  1  actual direction.
- `i_rs_hit`  in  1  the original lookup hit the BHT.
- `o_rs_ready`  out  1  FIFO can accept (= !full).
- `i_clear`  in  1  single-cycle request to invalidate the whole table.
- `o_tbl_cmd`  out  2  00 NOP, 01 READ, 10 WRITE (allocate/clear), 11 TRAIN.
- `o_tbl_index`  out  INDEX_WIDTH  table index for the command.
- `o_tbl_wr_pc`, `o_tbl_wr_target`  out  N  WRITE data.
- `o_tbl_wr_ctr`  out  2  WRITE initial counter.
- `o_tbl_taken`  out  1  TRAIN direction.
- `o_init_done`  out  1  table valid; high only in RUN.
- `o_perf_lookups`, `o_perf_updates`, `o_perf_stalls`  out  32  performance counters.

## Operation
- FSM states:
  - INIT: clear sweep.
  - RUN: normal arbitration.
  - DRAIN: empty the FIFO before a clear.
- INIT:
  - Sweep counter idx starts at 0.
  - Each cycle: cmd=WRITE, index=idx, wr_pc=0, wr_target=0, wr_ctr=2'b01, then idx+1.
  - After the cycle with idx = all-ones, go to RUN. The sweep takes exactly 2^INDEX_WIDTH cycles.
  - o_lu_ready=0 throughout.
- RUN, one command per cycle:
  - Forced update when the FIFO is full or starve_cnt ≥ STARVE_LIMIT: pop the FIFO head, o_lu_ready=0.
  - Otherwise, if i_lu_valid: cmd=READ, index=i_lu_pc[INDEX_WIDTH-1:0], o_lu_ready=1.
  - Otherwise, if the FIFO is non-empty: pop and update.
  - Otherwise: NOP.
- Update from the FIFO head:
  - Head hit=1: cmd=TRAIN, o_tbl_taken=head taken.
  - Head hit=0: cmd=WRITE with head pc/target, wr_ctr=2'b01.
  - Index = head pc[INDEX_WIDTH-1:0] in both cases.
- starve_cnt (saturating at STARVE_LIMIT):
  - Increments each RUN cycle the FIFO is non-empty and no pop occurs.
  - Clears on a pop or when the FIFO is empty.
- FIFO:
  - Push on i_rs_valid & o_rs_ready.
  - Pushes are accepted in every state, including INIT.
  - The FIFO is popped only in RUN and DRAIN.
  - When full, o_rs_ready=0 even if a pop occurs in the same cycle.
  - Push and pop in the same non-full cycle leave the count unchanged.
- i_clear:
  - In RUN: go to DRAIN.
  - In DRAIN: ignored.
  - In INIT: restart the sweep at idx=0.
- DRAIN:
  - Pop one update per cycle; o_lu_ready=0.
  - When the FIFO is empty (including on entry), go to INIT.
  - Pushes arriving during DRAIN are drained too.
- Unused data outputs are 0 when cmd ≠ WRITE.

## Timing
- Table command outputs and o_lu_ready are combinational from state, FIFO head and i_lu_*. The table samples them at the same clk edge.
- Lookup latency: the READ is issued in the accept cycle. The table returns its prediction the next cycle; the table owns that path.
- Resolution-to-update latency:
  - Minimum 1 cycle (push at edge k, pop in cycle k+1 if not blocked).
  - Maximum (STARVE_LIMIT+1)·FIFO_DEPTH cycles in RUN.
- Reset (async, any time): state=INIT, idx=0, FIFO empty, starve_cnt=0, counters=0.
- Output values in reset: o_lu_ready=0, o_rs_ready=1, o_init_done=0, o_tbl_cmd=10 (INIT sweep visible at index 0).
- o_init_done goes high the first cycle in RUN and low the cycle DRAIN is entered.

## Configuration
- `BPU_CTRL_PERF_EN` defined:
  - o_perf_lookups counts granted READs.
  - o_perf_updates counts FIFO pops.
  - o_perf_stalls counts cycles with i_lu_valid=1 and o_lu_ready=0.
  - All three are 32-bit, saturate at all-ones, and clear on rst only.
- Undefined: the ports remain and are tied to 0; no counter flops are built.

## Test plan
- Reset release → 256 consecutive WRITE cmds, index 0x00..0xFF, wr_ctr=01, o_lu_ready=0; o_init_done=1 on cycle 256.
- RUN, FIFO empty, lookup pc=0x1000_0040 → same cycle o_tbl_cmd=01, index=0x40, o_lu_ready=1.
- Continuous lookups plus one resolution pc=0x0000_0144, hit=1, taken=1 (STARVE_LIMIT=3) → 3 READ cycles, then TRAIN index=0x44, taken=1 with o_lu_ready=0; READs resume next cycle.
- Continuous lookups plus 4 back-to-back misses → o_rs_ready=0 after the 4th push; the next cycle is a forced WRITE with the head pc/target, wr_ctr=01.
- i_clear in RUN with 2 entries queued and lookups pending → 2 update cycles, then 256 clear cycles, then READ grants; o_init_done low throughout.
- With `BPU_CTRL_PERF_EN`: 5 granted lookups, 2 updates, 3 stall cycles → counters read 5/2/3. Without the macro: all counters read 0.
